// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one imem request at a time
// and presents fetched instructions to the fetch/decode register with a one-entry skid.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_F,
   output logic [31:0] PCP4_F,
   output logic [31:0] InstrF,
   output logic        ValidF
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state, state_n;
   logic [31:0] fetch_pc, fetch_pc_n;
   logic [31:0] addr_q, addr_n;
   logic        drop, drop_n;
   logic        skid_vld, skid_vld_n;
   logic [31:0] skid_pc, skid_pc_n;
   logic [31:0] skid_instr, skid_instr_n;
   logic [31:0] pc_q, pc_n;
   logic [31:0] instr_q, instr_n;
   logic        valid_q, valid_n;
   logic        accept, resp;
   logic [31:0] target;

   assign accept    = (state == S_REQ) && imem_ready;
   assign resp      = (state == S_WAIT) && imem_rvalid;
   assign target    = PCTargetE & ~32'd3;

   assign imem_req  = (state == S_REQ);
   assign imem_addr = addr_q;
   assign PC_F      = pc_q;
   assign PCP4_F    = pc_q + 32'd4;
   assign InstrF    = instr_q;
   assign ValidF    = valid_q;

   always_comb begin
      state_n      = state;
      fetch_pc_n   = fetch_pc;
      addr_n       = addr_q;
      drop_n       = drop;
      skid_vld_n   = skid_vld;
      skid_pc_n    = skid_pc;
      skid_instr_n = skid_instr;
      pc_n         = pc_q;
      instr_n      = instr_q;
      valid_n      = valid_q;

      if (!StallF) begin
         valid_n = 1'b0;
         instr_n = NOP_INSTR;
      end

      unique case (state)
         S_IDLE: begin
            state_n = S_REQ;
            addr_n  = fetch_pc;
         end
         S_REQ: begin
            if (accept) state_n = S_WAIT;
         end
         S_WAIT: begin
            if (resp) begin
               if (drop) begin
                  drop_n  = 1'b0;
                  state_n = S_REQ;
                  addr_n  = fetch_pc;
               end else begin
                  // addr_q still names the outstanding request while in WAIT
                  fetch_pc_n = fetch_pc + 32'd4;
                  addr_n     = fetch_pc + 32'd4;
                  if (valid_q && StallF) begin
                     skid_vld_n   = 1'b1;
                     skid_pc_n    = addr_q;
                     skid_instr_n = imem_rdata;
                     state_n      = S_HOLD;
                  end else begin
                     pc_n    = addr_q;
                     instr_n = imem_rdata;
                     valid_n = 1'b1;
                     state_n = S_REQ;
                  end
               end
            end
         end
         S_HOLD: begin
            if (!StallF) begin
               pc_n       = skid_pc;
               instr_n    = skid_instr;
               valid_n    = 1'b1;
               skid_vld_n = 1'b0;
               state_n    = S_REQ;
            end
         end
         default: state_n = S_IDLE;
      endcase

      // Redirect wins over stall and the transitions above; an unaccepted request
      // keeps its address on the bus and is dropped when it returns.
      if (PCSrcE) begin
         fetch_pc_n = target;
         valid_n    = 1'b0;
         instr_n    = NOP_INSTR;
         pc_n       = pc_q;
         skid_vld_n = 1'b0;
         unique case (state)
            S_REQ: begin
               state_n = accept ? S_WAIT : S_REQ;
               drop_n  = 1'b1;
               addr_n  = addr_q;
            end
            S_WAIT: begin
               if (resp) begin
                  state_n = S_REQ;
                  drop_n  = 1'b0;
                  addr_n  = target;
               end else begin
                  state_n = S_WAIT;
                  drop_n  = 1'b1;
               end
            end
            default: begin
               state_n = S_REQ;
               drop_n  = 1'b0;
               addr_n  = target;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         fetch_pc   <= RESET_PC;
         addr_q     <= RESET_PC;
         drop       <= 1'b0;
         skid_vld   <= 1'b0;
         skid_pc    <= '0;
         skid_instr <= '0;
         pc_q       <= RESET_PC;
         instr_q    <= NOP_INSTR;
         valid_q    <= 1'b0;
      end else begin
         state      <= state_n;
         fetch_pc   <= fetch_pc_n;
         addr_q     <= addr_n;
         drop       <= drop_n;
         skid_vld   <= skid_vld_n;
         skid_pc    <= skid_pc_n;
         skid_instr <= skid_instr_n;
         pc_q       <= pc_n;
         instr_q    <= instr_n;
         valid_q    <= valid_n;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory model plus a program-order PC reference that every
// consumed instruction is checked against, with directed cases followed by random traffic.
module tb_fetch_unit;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, StallF = 1'b0, PCSrcE = 1'b0;
   logic [31:0] PCTargetE = '0;
   logic        imem_req, ValidF;
   logic [31:0] imem_addr, PC_F, PCP4_F, InstrF;
   logic        imem_ready = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;

   logic        w_req, w_valid;
   logic [31:0] w_addr, w_pc, w_pcp4, w_instr;
   logic        w_rvalid = 1'b0;
   logic [31:0] w_rdata = '0;

   fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .PC_F(PC_F), .PCP4_F(PCP4_F), .InstrF(InstrF), .ValidF(ValidF));

   fetch_unit #(.RESET_PC(WRAP_PC), .NOP_INSTR(NOP)) u_wrap (
      .clk(clk), .rst(rst), .StallF(1'b0), .PCSrcE(1'b0), .PCTargetE(32'h0),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1),
      .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .PC_F(w_pc), .PCP4_F(w_pcp4), .InstrF(w_instr), .ValidF(w_valid));

   int unsigned total = 0, bad = 0;

   // reference state: next PC in program order, plus the memory's one pending request
   logic [31:0] exp_pc = '0, w_exp = WRAP_PC;
   int unsigned consumed = 0, w_consumed = 0;
   logic        pend = 1'b0, w_pend = 1'b0;
   logic [31:0] pend_addr = '0, w_pend_addr = '0;
   int unsigned pend_wait = 0;
   int unsigned lat_cfg = 1;     // 0 = random 1..3
   int unsigned ready_mode = 1;  // 0 low, 1 high, 2 random

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      logic        p_rst, p_stall, p_src, p_ready, p_rvalid, p_req, p_valid;
      logic        wp_req, wp_rvalid, wp_valid;
      logic [31:0] p_tgt, p_addr, p_pc, p_pcp4, p_instr, wp_addr, wp_pc, wp_pcp4, wp_instr;
      p_rst = rst; p_stall = StallF; p_src = PCSrcE; p_ready = imem_ready;
      p_rvalid = imem_rvalid; p_req = imem_req; p_valid = ValidF; p_tgt = PCTargetE;
      p_addr = imem_addr; p_pc = PC_F; p_pcp4 = PCP4_F; p_instr = InstrF;
      wp_req = w_req; wp_rvalid = w_rvalid; wp_valid = w_valid; wp_addr = w_addr;
      wp_pc = w_pc; wp_pcp4 = w_pcp4; wp_instr = w_instr;
      @(posedge clk);
      #1;
      if (p_rst) begin
         pend = 1'b0; exp_pc = '0;
         w_pend = 1'b0; w_exp = WRAP_PC;
      end else begin
         if (p_valid && !p_stall) begin
            chk("pc", p_pc, exp_pc);
            chk("pcp4", p_pcp4, exp_pc + 32'd4);
            chk("instr", p_instr, mem_word(exp_pc));
            exp_pc += 32'd4;
            consumed++;
         end
         if (p_src) exp_pc = p_tgt & ~32'd3;
         if (p_rvalid) pend = 1'b0;
         if (p_req && p_ready) begin
            chk("one_outstanding", 32'(pend), 32'd0);
            pend = 1'b1;
            pend_addr = p_addr;
            pend_wait = (lat_cfg != 0) ? lat_cfg : 1 + $urandom % 3;
         end
         if (p_req && !p_ready) begin
            chk("req_hold", 32'(imem_req), 32'd1);
            chk("addr_hold", imem_addr, p_addr);
         end
         if (wp_valid) begin
            chk("w_pc", wp_pc, w_exp);
            chk("w_pcp4", wp_pcp4, w_exp + 32'd4);
            chk("w_instr", wp_instr, mem_word(w_exp));
            w_exp += 32'd4;
            w_consumed++;
         end
         if (wp_rvalid) w_pend = 1'b0;
         if (wp_req) begin
            w_pend = 1'b1;
            w_pend_addr = wp_addr;
         end
      end
      if (!ValidF) chk("nop", InstrF, NOP);
      if (!w_valid) chk("w_nop", w_instr, NOP);
      if (pend && pend_wait <= 1) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pend_addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (pend) pend_wait--;
      end
      w_rvalid = w_pend;
      w_rdata  = w_pend ? mem_word(w_pend_addr) : 32'hDEAD_BEEF;
      case (ready_mode)
         0:       imem_ready = 1'b0;
         1:       imem_ready = 1'b1;
         default: imem_ready = ($urandom % 4) != 0;
      endcase
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_valid"}, 32'(ValidF), 32'd0);
      chk({tag, "_instr"}, InstrF, NOP);
      chk({tag, "_pc"}, PC_F, 32'h0);
      chk({tag, "_pcp4"}, PCP4_F, 32'h4);
      chk({tag, "_req"}, 32'(imem_req), 32'd0);
      chk({tag, "_addr"}, imem_addr, 32'h0);
   endtask

   initial begin
      logic [6:0]  pat;
      logic [31:0] snap_pc, snap_instr;
      int unsigned start, n;
      bit          hit;

      rst = 1'b1;
      tick(); tick();
      check_reset("rst");
      rst = 1'b0;

      // zero-wait memory: one instruction every two cycles at 0,4,8
      pat = 7'b1010100;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("t1_valid", 32'(ValidF), 32'(pat[i]));
         if (i % 2 == 0) begin
            chk("t1_req", 32'(imem_req), 32'd1);
            chk("t1_addr", imem_addr, 32'(i * 2));
         end
      end

      // stall with a valid slot: frozen outputs, skid fills, requests stop
      StallF = 1'b1;
      snap_pc = PC_F; snap_instr = InstrF;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t2_valid", 32'(ValidF), 32'd1);
         chk("t2_pc", PC_F, snap_pc);
         chk("t2_instr", InstrF, snap_instr);
         if (i >= 1) chk("t2_noreq", 32'(imem_req), 32'd0);
      end
      StallF = 1'b0;
      tick();
      chk("t2_skid_valid", 32'(ValidF), 32'd1);
      chk("t2_skid_pc", PC_F, 32'hC);

      // redirect while waiting on 0x10
      lat_cfg = 3;
      chk("t3_addr", imem_addr, 32'h10);
      tick();
      chk("t3_wait", 32'(imem_req), 32'd0);
      PCSrcE = 1'b1; PCTargetE = 32'h0000_0102;
      tick();
      PCSrcE = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin
         tick();
         chk("t3_novalid", 32'(ValidF), 32'd0);
         hit = imem_req;
      end
      chk("t3_req_seen", 32'(hit), 32'd1);
      chk("t3_target", imem_addr, 32'h100);
      hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin
         tick();
         hit = ValidF;
      end
      chk("t3_valid_seen", 32'(hit), 32'd1);
      chk("t3_pc", PC_F, 32'h100);

      // redirect on the same edge as rvalid, with a concurrent stall
      lat_cfg = 1;
      hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin
         tick();
         hit = imem_rvalid;
      end
      chk("t4_rvalid_seen", 32'(hit), 32'd1);
      PCSrcE = 1'b1; PCTargetE = 32'h0000_0200; StallF = 1'b1;
      tick();
      PCSrcE = 1'b0; StallF = 1'b0;
      chk("t4_valid", 32'(ValidF), 32'd0);
      chk("t4_req", 32'(imem_req), 32'd1);
      chk("t4_addr", imem_addr, 32'h200);

      // memory not ready: request held; then reset while waiting
      ready_mode = 0; imem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t6_req", 32'(imem_req), 32'd1);
         chk("t6_addr", imem_addr, 32'h200);
      end
      ready_mode = 1; imem_ready = 1'b1; lat_cfg = 3;
      tick();
      chk("t6_wait", 32'(imem_req), 32'd0);
      rst = 1'b1;
      tick();
      check_reset("t6_rst");
      rst = 1'b0;
      tick();
      chk("t6_req0", 32'(imem_req), 32'd1);
      chk("t6_addr0", imem_addr, 32'h0);

      // random traffic against the program-order reference
      ready_mode = 2; lat_cfg = 0;
      for (int i = 0; i < 4000; i++) begin
         StallF    = ($urandom % 3) == 0;
         PCSrcE    = ($urandom % 16) == 0;
         PCTargetE = $urandom;
         tick();
      end
      StallF = 1'b0; PCSrcE = 1'b0; ready_mode = 1; imem_ready = 1'b1;
      start = consumed;
      for (int i = 0; i < 60; i++) tick();
      n = consumed - start;
      chk("liveness", 32'(n >= 10), 32'd1);
      chk("wrap_progress", 32'(w_consumed >= 3), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
